if_fetch_unit: RTL and testbench

- Instruction-fetch front end of the 5-stage pipelined CPU; directly feeds the ID stage.
- Owns the PC and the IF/ID pipeline register, with valid bit, stall and flush support.
- Fetches through a req/ack handshake to instruction memory, so memory may have variable latency.
- A one-entry skid buffer absorbs an instruction that returns while ID is stalled. Branch/jump redirects arrive from EX/MEM.

---
 rtl/cpu_pkg.sv | 14 +
 rtl/fetch_skid_buf.sv | 35 +++
 rtl/if_fetch_unit.sv | 145 ++++++++++++++
 tb/tb_if_fetch_unit.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared types and constants for the CPU front end.
package cpu_pkg;
    localparam int PC_W    = 32;
    localparam int INSTR_W = 32;

    localparam logic [PC_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [PC_W-1:0] PC_STEP_DEFAULT  = 32'd4;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        HOLD
    } fetch_state_t;
endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry {pc, instr} holding slot for a fetch that returns while ID is stalled.
module fetch_skid_buf
    import cpu_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               drain,
    input  logic               clear,
    input  logic [PC_W-1:0]    wr_pc,
    input  logic [INSTR_W-1:0] wr_instr,
    output logic               valid,
    output logic [PC_W-1:0]    pc,
    output logic [INSTR_W-1:0] instr
);
    // clear (redirect) wins over a same-cycle load
    always_ff @(posedge clk) begin
        if (rst || clear)
            valid <= 1'b0;
        else if (load)
            valid <= 1'b1;
        else if (drain)
            valid <= 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc    <= '0;
            instr <= '0;
        end else if (load) begin
            pc    <= wr_pc;
            instr <= wr_instr;
        end
    end
endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: PC, req/ack fetch FSM, skid buffer and the IF/ID register.
module if_fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC = RESET_PC_DEFAULT,
    parameter logic [PC_W-1:0] PC_STEP  = PC_STEP_DEFAULT
) (
    input  logic               clk_i,
    input  logic               rst_i,
    output logic               imem_req_o,
    output logic [PC_W-1:0]    imem_addr_o,
    input  logic               imem_ack_i,
    input  logic [INSTR_W-1:0] imem_rdata_i,
    input  logic               stall_i,
    input  logic               redirect_i,
    input  logic [PC_W-1:0]    redirect_pc_i,
    output logic               ifid_valid_o,
    output logic [PC_W-1:0]    ifid_pc_o,
    output logic [PC_W-1:0]    ifid_pc4_o,
    output logic [INSTR_W-1:0] ifid_instr_o
);
    fetch_state_t       state_q, state_d;
    logic [PC_W-1:0]    req_addr_q, req_addr_d;
    logic [PC_W-1:0]    tgt_q, tgt_d;
    logic               kill_q, kill_d;
    logic [PC_W-1:0]    redir_tgt;
    logic               accept, good_ack;
    logic               ifid_load;
    logic [PC_W-1:0]    ifid_pc_d;
    logic [INSTR_W-1:0] ifid_instr_d;
    logic               skid_load, skid_drain, skid_valid;
    logic [PC_W-1:0]    skid_pc;
    logic [INSTR_W-1:0] skid_instr;

    assign redir_tgt   = redirect_pc_i & ~32'h3;
    assign imem_req_o  = (state_q == FETCH);
    assign imem_addr_o = req_addr_q;
    assign accept      = ~stall_i | ~ifid_valid_o;
    assign good_ack    = imem_req_o & imem_ack_i & ~kill_q & ~redirect_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            req_addr_q <= RESET_PC;
            tgt_q      <= '0;
            kill_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            req_addr_q <= req_addr_d;
            tgt_q      <= tgt_d;
            kill_q     <= kill_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        req_addr_d   = req_addr_q;
        tgt_d        = tgt_q;
        kill_d       = kill_q;
        ifid_load    = 1'b0;
        ifid_pc_d    = req_addr_q;
        ifid_instr_d = imem_rdata_i;
        skid_load    = 1'b0;
        skid_drain   = 1'b0;
        unique case (state_q)
            IDLE: begin
                state_d = FETCH;
                if (redirect_i)
                    req_addr_d = redir_tgt;
            end
            FETCH: begin
                if (redirect_i) begin
                    // an outstanding request must keep its address until acked
                    if (imem_ack_i) begin
                        req_addr_d = redir_tgt;
                        kill_d     = 1'b0;
                    end else begin
                        kill_d = 1'b1;
                        tgt_d  = redir_tgt;
                    end
                end else if (imem_ack_i && kill_q) begin
                    kill_d     = 1'b0;
                    req_addr_d = tgt_q;
                end else if (good_ack) begin
                    req_addr_d = req_addr_q + PC_STEP;
                    if (accept)
                        ifid_load = 1'b1;
                    else begin
                        skid_load = 1'b1;
                        state_d   = HOLD;
                    end
                end
            end
            HOLD: begin
                if (redirect_i) begin
                    req_addr_d = redir_tgt;
                    state_d    = FETCH;
                end else if (!stall_i) begin
                    ifid_load    = 1'b1;
                    ifid_pc_d    = skid_pc;
                    ifid_instr_d = skid_instr;
                    skid_drain   = 1'b1;
                    state_d      = FETCH;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // redirect flushes IF/ID ahead of both load and stall
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ifid_valid_o <= 1'b0;
            ifid_pc_o    <= '0;
            ifid_pc4_o   <= '0;
            ifid_instr_o <= '0;
        end else if (redirect_i) begin
            ifid_valid_o <= 1'b0;
        end else if (ifid_load) begin
            ifid_valid_o <= 1'b1;
            ifid_pc_o    <= ifid_pc_d;
            ifid_pc4_o   <= ifid_pc_d + 32'd4;
            ifid_instr_o <= ifid_instr_d;
        end else if (!(stall_i && ifid_valid_o)) begin
            ifid_valid_o <= 1'b0;
        end
    end

    fetch_skid_buf u_skid (
        .clk      (clk_i),
        .rst      (rst_i),
        .load     (skid_load),
        .drain    (skid_drain),
        .clear    (redirect_i),
        .wr_pc    (req_addr_q),
        .wr_instr (imem_rdata_i),
        .valid    (skid_valid),
        .pc       (skid_pc),
        .instr    (skid_instr)
    );

    // skid occupancy is implied by state HOLD; kept for visibility in waves
    logic skid_unused;
    assign skid_unused = skid_valid;
endmodule

// File: tb/tb_if_fetch_unit.sv
// Randomized bench: ID must see one contiguous program-order stream that restarts at each redirect target.
module tb_if_fetch_unit;
    localparam logic [31:0] KEY = 32'hA5A5_0000;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ack_i = 1'b0;
    logic [31:0] imem_rdata_i = '0;
    logic        stall_i = 1'b0;
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_pc_i = '0;
    logic        ifid_valid_o;
    logic [31:0] ifid_pc_o, ifid_pc4_o, ifid_instr_o;

    if_fetch_unit dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
        .imem_ack_i(imem_ack_i), .imem_rdata_i(imem_rdata_i),
        .stall_i(stall_i), .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
        .ifid_valid_o(ifid_valid_o), .ifid_pc_o(ifid_pc_o),
        .ifid_pc4_o(ifid_pc4_o), .ifid_instr_o(ifid_instr_o)
    );

    always #5 clk_i = ~clk_i;

    int n_cmp = 0;
    int n_err = 0;
    int delivered = 0;
    int mem_mode = 0;
    logic [31:0] exp_q[$];
    logic [31:0] seg_next = 32'h0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Architectural stream restarts at the aligned target; anything older is never delivered.
    task automatic restart(input logic [31:0] tgt);
        exp_q.delete();
        seg_next = tgt & 32'hFFFF_FFFC;
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back(seg_next);
            seg_next = seg_next + 32'd4;
        end
    endtask

    // Memory model: ack after cur_lat wait cycles, data = addr ^ KEY.
    int wait_cnt = 0;
    int cur_lat = 0;
    function automatic int pick_lat();
        if (mem_mode == 0) return 0;
        if (mem_mode == 1) return 2;
        return int'($urandom_range(0, 3));
    endfunction

    always @(posedge clk_i) begin
        if (rst_i || (imem_req_o && imem_ack_i)) begin
            wait_cnt = 0;
            cur_lat  = pick_lat();
        end else if (imem_req_o) begin
            wait_cnt++;
        end
        #1;
        if (imem_req_o && wait_cnt >= cur_lat) begin
            imem_ack_i   = 1'b1;
            imem_rdata_i = imem_addr_o ^ KEY;
        end else begin
            imem_ack_i   = 1'b0;
            imem_rdata_i = $urandom;
        end
    end

    // Monitor / scoreboard
    logic        prev_redir = 1'b0;
    logic        prev_pend = 1'b0;
    logic [31:0] prev_addr = '0;
    always @(negedge clk_i) begin
        if (!rst_i) begin
            if (prev_redir) chk("flush_valid", {31'b0, ifid_valid_o}, 32'd0);
            if (prev_pend) begin
                chk("req_hold", {31'b0, imem_req_o}, 32'd1);
                chk("addr_hold", imem_addr_o, prev_addr);
            end
            if (imem_req_o) chk("addr_align", {30'b0, imem_addr_o[1:0]}, 32'd0);
            if (ifid_valid_o && !stall_i && !redirect_i) begin
                logic [31:0] e;
                if (exp_q.size() == 0) begin
                    exp_q.push_back(seg_next);
                    seg_next = seg_next + 32'd4;
                end
                e = exp_q.pop_front();
                chk("ifid_pc", ifid_pc_o, e);
                chk("ifid_pc4", ifid_pc4_o, e + 32'd4);
                chk("ifid_instr", ifid_instr_o, e ^ KEY);
                delivered++;
            end
        end
        prev_redir = redirect_i && !rst_i;
        prev_pend  = imem_req_o && !imem_ack_i && !rst_i;
        prev_addr  = imem_addr_o;
    end

    logic [31:0] tgts [5] = '{32'h0000_0040, 32'h0000_0043, 32'hFFFF_FFFC, 32'hFFFF_FFF8, 32'h0};

    task automatic pulse_redirect(input logic [31:0] tgt);
        redirect_i    = 1'b1;
        redirect_pc_i = tgt;
        restart(tgt);
    endtask

    initial begin
        int cnt;
        logic last_redir;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        chk("rst_req", {31'b0, imem_req_o}, 32'd0);
        chk("rst_valid", {31'b0, ifid_valid_o}, 32'd0);
        chk("rst_pc", ifid_pc_o, 32'd0);
        chk("rst_pc4", ifid_pc4_o, 32'd0);
        chk("rst_instr", ifid_instr_o, 32'd0);

        restart(32'h0);
        @(posedge clk_i); #1 rst_i = 1'b0;
        @(posedge clk_i);
        @(negedge clk_i);
        chk("first_valid_early", {31'b0, ifid_valid_o}, 32'd0);
        chk("first_req", {31'b0, imem_req_o}, 32'd1);
        chk("first_addr", imem_addr_o, 32'h0);
        @(negedge clk_i);
        chk("first_valid", {31'b0, ifid_valid_o}, 32'd1);
        // zero-wait memory: one instruction per cycle
        repeat (20) begin
            @(negedge clk_i);
            chk("zw_tput", {31'b0, ifid_valid_o}, 32'd1);
        end

        // fixed 3-cycle memory: one valid every third cycle
        @(posedge clk_i); #1 mem_mode = 1;
        repeat (8) @(negedge clk_i);
        cnt = 0;
        repeat (30) begin
            @(negedge clk_i);
            if (ifid_valid_o) cnt++;
        end
        chk("lat3_rate_ok", {31'b0, (cnt >= 9 && cnt <= 11)}, 32'd1);

        // directed: redirect to the top of the address space, zero-wait
        @(posedge clk_i); #1 mem_mode = 0;
        repeat (3) @(posedge clk_i);
        #1 pulse_redirect(32'hFFFF_FFFC);
        @(posedge clk_i); #1 redirect_i = 1'b0;
        cnt = delivered;
        repeat (6) @(posedge clk_i);
        chk("wrap_progress", {31'b0, (delivered - cnt >= 4)}, 32'd1);

        // random latency, stalls and redirects
        mem_mode = 2;
        last_redir = 1'b0;
        repeat (800) begin
            @(posedge clk_i); #1;
            stall_i = ($urandom_range(0, 3) == 0);
            if (!last_redir && $urandom_range(0, 11) == 0) begin
                int k = int'($urandom_range(0, 4));
                pulse_redirect(k == 4 ? $urandom : tgts[k]);
                last_redir = 1'b1;
            end else begin
                redirect_i = 1'b0;
                last_redir = 1'b0;
            end
        end
        @(posedge clk_i); #1;
        stall_i = 1'b0;
        redirect_i = 1'b0;
        repeat (20) @(posedge clk_i);
        @(negedge clk_i);
        chk("progress", {31'b0, (delivered >= 120)}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
